// File: rtl/bist_sequencer.sv
// BIST session controller: seeds, runs and checks NUM_WINDOWS signature windows in learn or test mode.
// Optional BIST_STOP_ON_FAIL_EN: a test session ends at the first failing window.
module bist_sequencer #(
    parameter int unsigned NUM_WINDOWS = 14,
    parameter int unsigned WINDOW_LEN  = 8,
    localparam int unsigned CW = $clog2(NUM_WINDOWS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          learn,
    input  logic          abort,
    input  logic          pass_in,
    output logic          enl,
    output logic          ens,
    output logic          mode,
    output logic          cin,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [CW-1:0] fail_cnt,
    output logic [CW-1:0] first_fail
);
    localparam int unsigned RW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [CW-1:0] LAST_WIN = CW'(NUM_WINDOWS - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(NUM_WINDOWS);
    localparam logic [RW-1:0] LAST_RUN = RW'(WINDOW_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_CHECK, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_win_idx, w_win_nxt;
    logic [RW-1:0] r_run_cnt, w_run_nxt;
    logic          r_mode, w_mode_nxt;
    logic          r_fail, w_fail_nxt;
    logic [CW-1:0] r_fail_cnt, w_fcnt_nxt;
    logic [CW-1:0] r_first_fail, w_first_nxt;
    logic          r_enl, r_ens, r_cin, r_busy, r_done;
    logic          w_enl_nxt, w_ens_nxt, w_cin_nxt, w_busy_nxt, w_done_nxt;
    logic          w_win_fail;

    assign w_win_fail = r_mode && !pass_in;

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win_idx;
        w_run_nxt   = r_run_cnt;
        w_mode_nxt  = r_mode;
        w_fail_nxt  = r_fail;
        w_fcnt_nxt  = r_fail_cnt;
        w_first_nxt = r_first_fail;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_SEED;
                        w_mode_nxt  = ~learn;
                        w_fail_nxt  = 1'b0;
                        w_fcnt_nxt  = '0;
                        w_first_nxt = '0;
                        w_win_nxt   = '0;
                    end
                end
                S_SEED: begin
                    w_state_nxt = S_RUN;
                    w_run_nxt   = '0;
                end
                S_RUN: begin
                    w_run_nxt = r_run_cnt + 1'b1;
                    if (r_run_cnt == LAST_RUN) begin
                        w_state_nxt = S_CHECK;
                    end
                end
                S_CHECK: begin
                    w_run_nxt = '0;
                    if (w_win_fail) begin
                        w_fail_nxt = 1'b1;
                        if (r_fail_cnt != MAX_CNT) begin
                            w_fcnt_nxt = r_fail_cnt + 1'b1;
                        end
                        if (!r_fail) begin
                            w_first_nxt = r_win_idx;
                        end
                    end
`ifdef BIST_STOP_ON_FAIL_EN
                    if (w_win_fail || (r_win_idx == LAST_WIN)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_win_nxt   = r_win_idx + 1'b1;
                        w_state_nxt = S_RUN;
                    end
`else
                    if (r_win_idx == LAST_WIN) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_win_nxt   = r_win_idx + 1'b1;
                        w_state_nxt = S_RUN;
                    end
`endif
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
        // Strobes are decoded from the next state so they register alongside it.
        w_enl_nxt  = (w_state_nxt == S_SEED);
        w_ens_nxt  = (w_state_nxt == S_SEED) || (w_state_nxt == S_CHECK);
        w_cin_nxt  = (w_state_nxt == S_RUN) && w_win_nxt[0];
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_win_idx    <= '0;
            r_run_cnt    <= '0;
            r_mode       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
            r_enl        <= 1'b0;
            r_ens        <= 1'b0;
            r_cin        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_win_idx    <= w_win_nxt;
            r_run_cnt    <= w_run_nxt;
            r_mode       <= w_mode_nxt;
            r_fail       <= w_fail_nxt;
            r_fail_cnt   <= w_fcnt_nxt;
            r_first_fail <= w_first_nxt;
            r_enl        <= w_enl_nxt;
            r_ens        <= w_ens_nxt;
            r_cin        <= w_cin_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign enl        = r_enl;
    assign ens        = r_ens;
    assign mode       = r_mode;
    assign cin        = r_cin;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;
    assign fail_cnt   = r_fail_cnt;
    assign first_fail = r_first_fail;

endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench for bist_sequencer: per-session expectations queued at start, checked at done.
module tb_bist_sequencer;
    logic       clk = 1'b0;
    logic       rst, start, learn, abort, pass_in;
    logic       enl, ens, mode, cin, busy, done, fail;
    logic [3:0] fail_cnt, first_fail;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int       lat;
        bit       mode;
        bit       fail;
        bit [3:0] fcnt;
        bit [3:0] ffirst;
        int       enl_n;
        int       ens_n;
    } exp_t;
    exp_t sb[$];

    bist_sequencer #(.NUM_WINDOWS(14), .WINDOW_LEN(8)) dut (
        .clk(clk), .rst(rst), .start(start), .learn(learn), .abort(abort),
        .pass_in(pass_in), .enl(enl), .ens(ens), .mode(mode), .cin(cin),
        .busy(busy), .done(done), .fail(fail), .fail_cnt(fail_cnt),
        .first_fail(first_fail)
    );

    always #5 clk = ~clk;

    function automatic bit is_check(input int s);
        return (s >= 9) && (s <= 126) && ((s % 9) == 0);
    endfunction

    function automatic bit exp_cin(input int s);
        if (s < 1 || s > 126 || ((s - 1) % 9) >= 8) return 1'b0;
        return 1'(((s - 1) / 9) % 2);
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; learn = 1'b0; abort = 1'b0; pass_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({enl, ens, mode, cin, busy, done, fail, fail_cnt, first_fail} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {enl, ens, mode, cin, busy, done, fail, fail_cnt, first_fail});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_session(input bit lrn, input logic [15:0] mask, input bit hold_start);
        exp_t e, g;
        int   s, lat, enl_n, ens_n, bad;
        bit   got_done;
        string bad_msg;
        e.mode = !lrn; e.fail = 0; e.fcnt = 0; e.ffirst = 0;
        e.lat = 127; e.enl_n = 1; e.ens_n = 15;
        if (!lrn) begin
            for (int w = 0; w < 14; w++) begin
                if (mask[w]) begin
                    if (!e.fail) e.ffirst = 4'(w);
                    e.fail = 1;
                    e.fcnt = e.fcnt + 4'd1;
`ifdef BIST_STOP_ON_FAIL_EN
                    e.lat = 10 + 9 * w; e.ens_n = w + 2;
                    break;
`endif
                end
            end
        end
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; learn = lrn; abort = 1'b0;
        @(posedge clk);
        s = 0; lat = -1; enl_n = 0; ens_n = 0; bad = 0; got_done = 0; bad_msg = "";
        while (s < 300 && !got_done) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (enl) enl_n++;
            if (ens) ens_n++;
            if (done) begin
                got_done = 1; lat = s;
            end else begin
                if (enl !== (s == 0) || ens !== (s == 0 || is_check(s)) ||
                    cin !== exp_cin(s) || busy !== 1'b1 ||
                    (s == 0 && (fail !== 1'b0 || fail_cnt !== 4'd0))) begin
                    if (bad == 0)
                        bad_msg = $sformatf("cycle %0d enl=%b ens=%b cin=%b busy=%b fail=%b", s, enl, ens, cin, busy, fail);
                    bad++;
                end
                if (lrn) pass_in = 1'b0;
                else if (is_check(s)) pass_in = ~mask[(s - 9) / 9];
                else pass_in = 1'($urandom_range(0, 1));
                s++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ctrl_pattern: %0d bad cycles, first %s, required SEED/RUN/CHECK strobes", bad, bad_msg);
        end
        n_checks++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL done_timeout: got no done in 300 cycles, expected at %0d", e.lat);
            void'(sb.pop_front());
        end else begin
            g = sb.pop_front();
            if (lat != g.lat) begin n_fail++; $display("FAIL done_latency: got %0d expected %0d", lat, g.lat); end
            n_checks++;
            if (mode !== g.mode) begin n_fail++; $display("FAIL mode: got %b expected %b", mode, g.mode); end
            n_checks++;
            if (fail !== g.fail) begin n_fail++; $display("FAIL fail_flag: got %b expected %b", fail, g.fail); end
            n_checks++;
            if (fail_cnt !== g.fcnt) begin n_fail++; $display("FAIL fail_cnt: got %0d expected %0d", fail_cnt, g.fcnt); end
            n_checks++;
            if (first_fail !== g.ffirst) begin n_fail++; $display("FAIL first_fail: got %0d expected %0d", first_fail, g.ffirst); end
            n_checks++;
            if (enl_n != g.enl_n) begin n_fail++; $display("FAIL enl_pulses: got %0d expected %0d", enl_n, g.enl_n); end
            n_checks++;
            if (ens_n != g.ens_n) begin n_fail++; $display("FAIL ens_pulses: got %0d expected %0d", ens_n, g.ens_n); end
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || enl !== 1'b0 || fail !== g.fail || fail_cnt !== g.fcnt) begin
            n_fail++;
            $display("FAIL post_done_idle: got busy=%b done=%b enl=%b fail=%b cnt=%0d expected idle with held status",
                     busy, done, enl, fail, fail_cnt);
        end
    endtask

    task automatic test_learn();
        run_session(1'b1, 16'h0000, 1'b0);
    endtask

    task automatic test_all_pass();
        run_session(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_fail_windows();
        run_session(1'b0, 16'h0208, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_session(1'b0, 16'h3FFF, 1'b1);
        run_session(1'b0, 16'h2001, 1'b0);
    endtask

    task automatic test_start_abort_idle();
        int bad = 0;
        @(negedge clk);
        start = 1'b1; abort = 1'b1; learn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || enl !== 1'b0 || ens !== 1'b0) bad++;
        end
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL start_abort_idle: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_abort();
        int s, seen_done;
        @(negedge clk);
        start = 1'b1; learn = 1'b0; abort = 1'b0;
        @(posedge clk);
        for (s = 0; s < 50; s++) begin
            @(negedge clk);
            start = 1'b0;
            if (s == 49) abort = 1'b1;
            else if (is_check(s)) pass_in = (s != 27);
            else pass_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({busy, done, enl, ens, cin} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy/done/enl/ens/cin=%b expected 00000", {busy, done, enl, ens, cin});
        end
        n_checks++;
        if (fail !== 1'b1 || fail_cnt !== 4'd1 || first_fail !== 4'd2 || mode !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_status: got fail=%b cnt=%0d first=%0d mode=%b expected 1 1 2 1",
                     fail, fail_cnt, first_fail, mode);
        end
        seen_done = 0;
        repeat (140) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", seen_done);
        end
        run_session(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start = 1'b1; learn = 1'b0;
        @(posedge clk);
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            start = 1'b0;
            pass_in = is_check(s) ? 1'b0 : 1'b1;
        end
        n_checks++;
        if (fail !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_fail: got %b expected 1", fail);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({enl, ens, mode, cin, busy, done, fail, fail_cnt, first_fail} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected all zero",
                     {enl, ens, mode, cin, busy, done, fail, fail_cnt, first_fail});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_learn();
        test_all_pass();
        test_fail_windows();
        test_back_to_back();
        test_start_abort_idle();
        test_abort();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion expected finish before 500000");
        $fatal(1);
    end
endmodule
